// File: rtl/core_pkg.sv
// core_pkg: shared hazard-tracker types, encodings and parameter legality checks.
package core_pkg;
    localparam int RA_BIT     = 5;
    localparam int FWD_SEL_RF = 0;
    typedef struct packed {
        logic              valid;
        logic [RA_BIT-1:0] dest;
        logic              is_load;
    } hz_entry_t;
    function automatic bit stages_legal(input int s);
        return s >= 1 && s <= 7;
    endfunction
    function automatic bit srcs_legal(input int n);
        return n >= 1 && n <= 4;
    endfunction
    function automatic bit load_stage_legal(input int l, input int s);
        return l >= 1 && l <= s;
    endfunction
endpackage

// File: rtl/cmb_fwd_select.sv
// cmb_fwd_select: per-port youngest-writer search returning forwarding select and load-use hazard.
module cmb_fwd_select
    import core_pkg::*;
#(
    parameter int STAGES     = 3,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_BIT    = 2
) (
    input  hz_entry_t [STAGES:1] i_entry,
    input  logic [RA_BIT-1:0]    i_req,
    output logic [SEL_BIT-1:0]   o_sel,
    output logic                 o_hazard
);
    // Walk oldest to youngest so the smallest matching stage is the last one written.
    always_comb begin
        o_sel    = SEL_BIT'(FWD_SEL_RF);
        o_hazard = 1'b0;
        for (int k = STAGES; k >= 1; k--)
            if (i_req != '0 && i_entry[k].valid && i_entry[k].dest == i_req) begin
                o_sel    = SEL_BIT'(k);
                o_hazard = i_entry[k].is_load && (k < LOAD_STAGE);
            end
    end
endmodule

// File: rtl/syn_hazard_tracker.sv
// syn_hazard_tracker: in-flight write scoreboard driving forwarding selects and load-use stall.
module syn_hazard_tracker
    import core_pkg::*;
#(
    parameter int STAGES     = 3,
    parameter int SRCS       = 2,
    parameter int RA_BIT     = core_pkg::RA_BIT,
    parameter int LOAD_STAGE = 2,
    localparam int SEL_BIT   = $clog2(STAGES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     id_valid,
    input  logic                     id_w_en,
    input  logic [RA_BIT-1:0]        id_req_w,
    input  logic                     id_is_load,
    input  logic [SRCS*RA_BIT-1:0]   id_req,
    output logic                     stall,
    output logic [SRCS*SEL_BIT-1:0]  fwd_sel,
    output logic [SEL_BIT-1:0]       inflight
);
    if (!stages_legal(STAGES)) begin : g_bad_stages
        $error("STAGES out of range");
    end
    if (!srcs_legal(SRCS)) begin : g_bad_srcs
        $error("SRCS out of range");
    end
    if (!load_stage_legal(LOAD_STAGE, STAGES)) begin : g_bad_load
        $error("LOAD_STAGE out of range");
    end
    if (RA_BIT != core_pkg::RA_BIT) begin : g_bad_ra
        $error("RA_BIT must match the entry type width");
    end
    hz_entry_t [STAGES:1] r_entry;
    hz_entry_t            w_new;
    logic [SRCS-1:0]      w_hazard;
    for (genvar i = 0; i < SRCS; i++) begin : g_port
        cmb_fwd_select #(
            .STAGES    (STAGES),
            .LOAD_STAGE(LOAD_STAGE),
            .SEL_BIT   (SEL_BIT)
        ) u_sel (
            .i_entry (r_entry),
            .i_req   (id_req[i*RA_BIT +: RA_BIT]),
            .o_sel   (fwd_sel[i*SEL_BIT +: SEL_BIT]),
            .o_hazard(w_hazard[i])
        );
    end
    assign stall = id_valid && !flush && |w_hazard;
    // A stalled or flushed slot enters as a bubble while older entries keep moving.
    assign w_new = '{valid:   id_valid && id_w_en && id_req_w != '0 && !stall && !flush,
                     dest:    id_req_w,
                     is_load: id_is_load};
    always_ff @(posedge clk) begin
        if (rst)
            r_entry <= '0;
        else if (en) begin
            for (int k = STAGES; k >= 2; k--)
                r_entry[k] <= r_entry[k-1];
            r_entry[1] <= w_new;
        end
    end
    always_comb begin
        inflight = '0;
        for (int k = 1; k <= STAGES; k++)
            inflight = inflight + SEL_BIT'(r_entry[k].valid);
    end
endmodule

// File: tb/tb_syn_hazard_tracker.sv
// tb_syn_hazard_tracker: directed vectors with a queued scoreboard checked on the falling edge.
module tb_syn_hazard_tracker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_w_en = 1'b0;
    logic [4:0]  id_req_w = '0;
    logic        id_is_load = 1'b0;
    logic [9:0]  id_req = '0;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic [1:0]  inflight;
    int          checks = 0;
    int          errors = 0;
    logic [6:0]  exp_q[$];
    string       name_q[$];
    logic [6:0]  m_exp;
    logic [6:0]  m_act;
    string       m_name;

    syn_hazard_tracker dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_w_en   (id_w_en),
        .id_req_w  (id_req_w),
        .id_is_load(id_is_load),
        .id_req    (id_req),
        .stall     (stall),
        .fwd_sel   (fwd_sel),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, e, f, v, w, input logic [4:0] d, input logic l,
                        input logic [4:0] a1, a0, input logic x_st,
                        input logic [1:0] x1, x0, x_in, input string nm);
        @(posedge clk);
        #1;
        rst = r; en = e; flush = f; id_valid = v; id_w_en = w;
        id_req_w = d; id_is_load = l; id_req = {a1, a0};
        exp_q.push_back({x_st, x1, x0, x_in});
        name_q.push_back(nm);
    endtask

    initial forever begin
        @(negedge clk);
        if (exp_q.size() != 0) begin
            m_exp  = exp_q.pop_front();
            m_name = name_q.pop_front();
            m_act  = {stall, fwd_sel, inflight};
            checks++;
            if (m_act !== m_exp) begin
                errors++;
                $display("FAIL %s: got stall=%0b sel1=%0d sel0=%0d inflight=%0d, want stall=%0b sel1=%0d sel0=%0d inflight=%0d",
                         m_name, m_act[6], m_act[5:4], m_act[3:2], m_act[1:0],
                         m_exp[6], m_exp[5:4], m_exp[3:2], m_exp[1:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        //    rst en fl v  w  dest  ld a1  a0   st s1 s0 inf
        step(0, 1, 0, 0, 0, 5'd0,  0, 0,  0,   0, 0, 0, 0, "reset");
        step(0, 1, 0, 1, 1, 5'd3,  0, 0,  0,   0, 0, 0, 0, "issue_add3");
        step(0, 1, 0, 1, 0, 5'd0,  0, 0,  3,   0, 0, 1, 1, "chain_s1");
        step(0, 1, 0, 1, 0, 5'd0,  0, 0,  3,   0, 0, 2, 1, "chain_s2");
        step(0, 1, 0, 1, 0, 5'd0,  0, 0,  3,   0, 0, 3, 1, "chain_s3");
        step(0, 1, 0, 1, 0, 5'd0,  0, 0,  3,   0, 0, 0, 0, "chain_retired");
        step(0, 1, 0, 1, 1, 5'd9,  0, 0,  0,   0, 0, 0, 0, "issue_add9");
        step(0, 1, 0, 1, 1, 5'd5,  1, 0,  0,   0, 0, 0, 1, "issue_lw5");
        step(0, 1, 0, 1, 1, 5'd6,  0, 5,  0,   1, 1, 0, 2, "load_use_stall");
        step(0, 1, 0, 1, 1, 5'd6,  0, 5,  0,   0, 2, 0, 2, "load_use_release");
        step(0, 1, 0, 1, 1, 5'd7,  0, 0,  0,   0, 0, 0, 2, "issue_add7a");
        step(0, 1, 0, 0, 0, 5'd0,  0, 0,  0,   0, 0, 0, 2, "bubble");
        step(0, 1, 0, 1, 1, 5'd7,  0, 0,  0,   0, 0, 0, 2, "issue_add7b");
        step(0, 1, 0, 1, 0, 5'd0,  0, 0,  7,   0, 0, 1, 2, "youngest_wins");
        step(0, 1, 0, 0, 0, 5'd0,  0, 0,  0,   0, 0, 0, 1, "drain1");
        step(0, 1, 0, 0, 0, 5'd0,  0, 0,  0,   0, 0, 0, 1, "drain2");
        step(0, 1, 0, 1, 1, 5'd0,  0, 0,  0,   0, 0, 0, 0, "write_r0");
        step(0, 1, 0, 1, 0, 5'd0,  0, 0,  0,   0, 0, 0, 0, "read_r0");
        step(0, 1, 0, 1, 1, 5'd5,  1, 0,  0,   0, 0, 0, 0, "issue_lw5_f");
        step(0, 1, 1, 1, 1, 5'd8,  0, 5,  0,   0, 1, 0, 1, "flush_over_stall");
        step(0, 1, 0, 1, 0, 5'd0,  0, 5,  0,   0, 2, 0, 1, "post_flush");
        step(0, 1, 0, 1, 1, 5'd10, 0, 0,  0,   0, 0, 0, 1, "issue_w10");
        step(0, 1, 0, 1, 1, 5'd11, 0, 0,  0,   0, 0, 0, 1, "issue_w11");
        step(0, 1, 0, 1, 1, 5'd12, 0, 0,  0,   0, 0, 0, 2, "issue_w12");
        step(0, 0, 0, 1, 1, 5'd13, 0, 12, 10,  0, 1, 3, 3, "hold1");
        step(0, 0, 0, 1, 1, 5'd13, 0, 12, 10,  0, 1, 3, 3, "hold2");
        step(1, 0, 0, 1, 1, 5'd13, 0, 12, 10,  0, 1, 3, 3, "rst_pre");
        step(0, 1, 0, 1, 1, 5'd13, 0, 12, 10,  0, 0, 0, 0, "post_rst");
        step(0, 1, 0, 1, 1, 5'd14, 1, 0,  0,   0, 0, 0, 1, "issue_lw14");
        step(0, 1, 0, 0, 1, 5'd15, 0, 14, 13,  0, 1, 2, 2, "no_valid_no_stall");
        step(1, 1, 0, 1, 1, 5'd15, 0, 14, 13,  0, 2, 3, 2, "rst_mid_pre");
        step(0, 1, 0, 1, 0, 5'd0,  0, 14, 13,  0, 0, 0, 0, "rst_mid_post");
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/syn_hazard_tracker.md
# syn_hazard_tracker

Parametrised in-flight-write scoreboard and forwarding controller for the pipelined core. It replaces the fixed two-port, two-stage collision detection with a generic block: N tracked stages, M source ports, and a configurable load-result stage. It sits in ID. It consumes the decoded instruction's sources and destination, drives per-source forwarding selects to the EX redirect muxes, and drives a load-use stall to PC, IF/ID and ID/EX.

## Interface
Parameters:
- STAGES, 3, number of tracked stages after ID (1 = EX, 2 = DM, 3 = WB); legal 1..7
- SRCS, 2, number of source register ports; legal 1..4
- RA_BIT, 5, register address width
- LOAD_STAGE, 2, first stage index from which a load result is forwardable; legal 1..STAGES
- SEL_BIT, derived as clog2(STAGES+1), forwarding-select width

Ports:
- clk  in  1  clock; one clock domain, all state on rising edge
- rst  in  1  reset; synchronous and active-high
- en  in  1  global advance enable; when low, state holds
- flush  in  1  redirect (jump or branch taken); squashes the ID instruction
- id_valid  in  1  ID holds a real instruction
- id_w_en  in  1  ID instruction writes the regfile
- id_req_w  in  RA_BIT  ID destination register
- id_is_load  in  1  ID instruction's result comes from data memory
- id_req  in  SRCS*RA_BIT  source registers; port i occupies bits [i*RA_BIT +: RA_BIT]
- stall  out  1  load-use hazard; hold PC and IF/ID, insert bubble
- fwd_sel  out  SRCS*SEL_BIT  per-port select; 0 = regfile, k = result of stage k
- inflight  out  SEL_BIT  count of valid tracked entries

## Operation
- State is a shift chain entry[1..STAGES]. Each entry holds {valid, dest, is_load}.
- Per-port search (combinational), for port i with r = id_req[i]:
  - If r == 0, then fwd_sel[i] = 0 and there is no hazard.
  - Otherwise, find the smallest k with entry[k].valid and entry[k].dest == r.
  - If no such k exists, fwd_sel[i] = 0.
  - fwd_sel[i] = k otherwise.
  - Hazard[i] = entry[k].is_load && k < LOAD_STAGE.
- The youngest matching writer always wins. Older matches are ignored.
- stall = OR of hazard[i] over all ports, gated by id_valid && !flush. When flush is asserted, stall is 0.
- fwd_sel is driven with the search result even while stall = 1. Consumers ignore it in that case.
- Advance, when en = 1:
  - entry[k] <= entry[k-1] for k = 2..STAGES.
  - entry[STAGES] retires.
  - entry[1] <= {id_valid && id_w_en && id_req_w != 0 && !stall && !flush, id_req_w, id_is_load}.
  - A stalled or flushed cycle therefore inserts a bubble (valid = 0). Downstream entries keep shifting.
- When en = 0, no entry changes. Outputs still reflect the current state and inputs.
- Writes to $0 are never recorded as valid.
- inflight = popcount of entry[k].valid.

## Timing
- Zero-latency outputs: stall, fwd_sel and inflight are combinational from the entries plus the current id_* and flush inputs.
- An instruction issued at edge t occupies stage k during cycle t+k-1 and retires after edge t+STAGES.
- A load-use stall lasts exactly LOAD_STAGE-1 cycles when the load is in stage 1 (1 cycle at the defaults). Holding conditions extend it.
- The stage-STAGES entry is still forwarded. The regfile write-back is not assumed write-through.
- Reset: on the rst edge, all entries become invalid. After reset, stall = 0, fwd_sel = 0 and inflight = 0.
  - rst takes priority over en and flush.
  - A mid-operation reset drops all in-flight entries with no residual forwarding.
- flush and stall in the same cycle: flush wins. stall = 0 and entry[1] becomes a bubble.

## Structure
- Shared package core_pkg holds:
  - RA_BIT
  - the hazard entry typedef {valid, dest, is_load}
  - the FWD_SEL_RF = 0 encoding
  - the legal-range checks for STAGES and LOAD_STAGE
- One sub-module, cmb_fwd_select: the per-port priority search over the entry vector. It returns the select and the hazard bit. The top instantiates it SRCS times via generate.
- The top holds only the entry registers, the insertion/advance logic, the stall OR and the inflight popcount.

## Test plan
All scenarios use the defaults: STAGES = 3, SRCS = 2, LOAD_STAGE = 2.
- Non-load forwarding chain:
  - Stimulus: issue add with id_req_w = 3, then present id_req = {0, 3} on the following cycles.
  - Response: fwd_sel[0] = 1, 2, 3, then 0 on successive cycles; stall = 0 throughout.
- Load-use:
  - Stimulus: issue lw with id_req_w = 5, then port 1 reads 5 on the next cycle.
  - Response: stall = 1 for one cycle and entry[1] becomes a bubble. The next cycle gives stall = 0, fwd_sel[1] = 2, inflight = 2.
- Youngest writer wins:
  - Stimulus: writers to $7 are valid in stage 1 and stage 3; port 0 reads 7.
  - Response: fwd_sel[0] = 1.
- $0 handling:
  - Stimulus: issue id_w_en = 1 with id_req_w = 0; next cycle both ports read 0.
  - Response: inflight = 0, fwd_sel = 0, stall = 0.
- flush over stall:
  - Stimulus: lw $5 is in stage 1, the ID instruction reads $5, and flush = 1.
  - Response: stall = 0; after the edge, entry[1] is invalid and the lw is in stage 2.
- Reset and enable:
  - Stimulus: with 3 valid entries, hold en = 0 for 2 cycles, then assert rst = 1.
  - Response: state holds (inflight = 3) during en = 0. After the rst edge, inflight = 0, all fwd_sel = 0 and stall = 0.
